// File: rtl/mac_array_scheduler.sv
// ---------------------------------------------------------------------------
// mac_array_scheduler
//
// Purpose:
//   Runs one job on the 49-lane Q8.8 MAC array and its pipelined 49-input
//   adder tree. A job has four phases:
//     1. Clear the accumulators.
//     2. Stream num_steps operand beats into the array.
//     3. Drain the MAC and adder-tree pipeline.
//     4. Present one Q22.16 result until the consumer accepts it.
//   The scheduler drives every control strobe of the datapath. It does no
//   arithmetic of its own.
//
// Ports:
//   clk        in   1       clock, all logic on the rising edge
//   rst        in   1       asynchronous, active-low reset
//   start      in   1       job request, only looked at in IDLE
//   num_steps  in   STEP_W  beats per job, latched when start is accepted
//   busy       out  1       high in every state except IDLE
//   op_valid   in   1       operand-pack beat available from fetch
//   op_ready   out  1       scheduler accepts a beat (FEED only)
//   mac_clr    out  1       synchronous clear of all 49 accumulators
//   mac_en     out  1       accumulate enable, op_valid & op_ready
//   tree_en    out  1       adder-tree pipeline advance (DRAIN only)
//   tree_sum   in   SUM_W   adder-tree output
//   res_data   out  SUM_W   captured job result
//   res_valid  out  1       result available (OUT only)
//   res_ready  in   1       consumer accepts the result
//   done       out  1       one-cycle pulse on the result handshake
//
// Optional feature:
//   MAC_SCHED_RELU_EN
//     Defined:   a negative tree_sum (MSB set) is captured as 0.
//     Undefined: tree_sum is captured unchanged.
//   Timing and handshakes are the same in both builds.
// ---------------------------------------------------------------------------
module mac_array_scheduler #(
    parameter int STEP_W   = 8,
    parameter int MAC_LAT  = 1,
    parameter int TREE_LAT = 6,
    parameter int SUM_W    = 38
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [STEP_W-1:0] num_steps,
    output logic              busy,
    input  logic              op_valid,
    output logic              op_ready,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              tree_en,
    input  logic [SUM_W-1:0]  tree_sum,
    output logic [SUM_W-1:0]  res_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              done
);

    // The drain has to cover the accumulator update plus the full tree
    // depth. Only then does the last beat's contribution reach tree_sum.
    localparam int DRAIN_CYC = MAC_LAT + TREE_LAT;
    localparam int DRAIN_W   = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        OUT
    } state_t;

    state_t              state;
    state_t              next_state;

    logic [STEP_W-1:0]   step_target;
    logic [STEP_W-1:0]   step_cnt;
    logic [DRAIN_W-1:0]  drain_cnt;

    logic                beat;
    logic                step_last;
    logic                drain_last;
    logic [SUM_W-1:0]    capture_val;

    // A beat is accepted only while FEED presents op_ready.
    // step_last marks the beat that completes the latched count. It is only
    // consulted in FEED, where the count is known to be nonzero, so the
    // subtraction cannot wrap in a way that matters.
    assign beat       = op_valid & (state == FEED);
    assign step_last  = (step_cnt == STEP_W'(step_target - 1'b1));
    assign drain_last = (drain_cnt == DRAIN_LAST);

    // Result capture path. With the ReLU option a negative Q22.16 sum is
    // clamped to zero. Otherwise the signed sum is passed through bit for bit.
`ifdef MAC_SCHED_RELU_EN
    assign capture_val = tree_sum[SUM_W-1] ? '0 : tree_sum;
`else
    assign capture_val = tree_sum;
`endif

    // State register. Reset drops any in-flight job and returns to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and strobe decode. Every strobe is a pure function of the
    // state, plus op_valid and res_ready for the two handshakes, so nothing
    // lags by a cycle. In OUT the tree stays frozen because tree_en is low.
    // A start seen in the done cycle is ignored, because only IDLE looks at
    // start. This forces at least one IDLE cycle between jobs.
    always_comb begin
        next_state = state;
        busy       = 1'b1;
        op_ready   = 1'b0;
        mac_en     = 1'b0;
        mac_clr    = 1'b0;
        tree_en    = 1'b0;
        res_valid  = 1'b0;
        done       = 1'b0;

        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = CLEAR;
                end
            end

            CLEAR: begin
                mac_clr = 1'b1;
                if (step_target != '0) begin
                    next_state = FEED;
                end else begin
                    next_state = DRAIN;
                end
            end

            FEED: begin
                op_ready = 1'b1;
                mac_en   = op_valid;
                if (beat && step_last) begin
                    next_state = DRAIN;
                end
            end

            DRAIN: begin
                tree_en = 1'b1;
                if (drain_last) begin
                    next_state = OUT;
                end
            end

            OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    done       = 1'b1;
                    next_state = IDLE;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Job bookkeeping and result capture.
    //   - The step target is latched on an accepted start.
    //   - Both counters are rewound at that point, so every job starts clean
    //     even after an aborted one.
    //   - res_data is written only in the last DRAIN cycle. It therefore
    //     stays stable through OUT and holds until the next job's capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_target <= '0;
            step_cnt    <= '0;
            drain_cnt   <= '0;
            res_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        step_target <= num_steps;
                        step_cnt    <= '0;
                        drain_cnt   <= '0;
                    end
                end

                FEED: begin
                    if (beat) begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end

                DRAIN: begin
                    drain_cnt <= drain_cnt + 1'b1;
                    if (drain_last) begin
                        res_data <= capture_val;
                    end
                end

                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mac_array_scheduler.md
Name: mac_array_scheduler

Overview:
- Sequences one job on the 49-lane Q8.8 MAC array and its pipelined 49-input adder tree: clear accumulators, stream NUM_STEPS operand beats, drain the pipeline, present one Q22.16 result.
- Sits between the NPU job/operand fetch logic and the MAC array + adder tree datapath.
- Owns every control strobe of that datapath: clear, accumulate enable, tree enable, result capture.

Parameters:
- STEP_W, 8, width of the step count (max 255 beats per job)
- MAC_LAT, 1, cycles from an accepted beat to the accumulator output updating
- TREE_LAT, 6, adder tree pipeline depth in cycles
- SUM_W, 38, result width (Q22.16)

Ports:
- clk  in  1  clock; all logic rising-edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  job request; sampled only in IDLE
- num_steps  in  STEP_W  beats per job; latched on accepted start
- busy  out  1  high in every state except IDLE
- op_valid  in  1  operand-pack beat available from fetch
- op_ready  out  1  scheduler accepts a beat
- mac_clr  out  1  synchronous clear of all 49 accumulators
- mac_en  out  1  accumulate enable; equals op_valid & op_ready
- tree_en  out  1  adder tree pipeline advance
- tree_sum  in  SUM_W  adder tree output
- res_data  out  SUM_W  captured job result
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- done  out  1  one-cycle pulse on the result handshake

Behaviour:
- Reset (rst=0, any state, including mid-job):
  - state=IDLE; all counters=0.
  - busy, op_ready, mac_en, mac_clr, tree_en, res_valid, done all 0; res_data=0.
  - Any in-flight job is discarded.
- States: IDLE, CLEAR, FEED, DRAIN, OUT.
- IDLE:
  - On start=1, latch num_steps and go to CLEAR.
  - start in any other state is ignored.
- CLEAR:
  - Exactly one cycle with mac_clr=1.
  - Next state is FEED if the latched count is nonzero, else DRAIN.
- FEED:
  - op_ready=1.
  - Each cycle with op_valid=1 is one accepted beat: mac_en=1 and the step counter increments.
  - op_valid=0 stalls with no timeout; mac_en=0 during the stall.
  - After the beat where the step count reaches the latched count, go to DRAIN. op_ready is 0 from the next cycle.
- DRAIN:
  - tree_en=1; a drain counter runs for MAC_LAT+TREE_LAT cycles.
  - In the final DRAIN cycle, capture tree_sum into res_data, then go to OUT.
  - Zero-step job: the cleared accumulators drain and the result is 0.
- OUT:
  - res_valid=1; res_data is held stable.
  - tree_en=0; the tree contents are frozen.
  - On res_valid & res_ready: done=1 for that cycle, res_valid drops next cycle, state returns to IDLE.
  - A start presented in that same cycle is not accepted; it must be held or re-issued.
- Latency:
  - First beat accepted no earlier than start-accept + 2 cycles.
  - With op_valid held at 1: start-accept to res_valid = 2 + N + MAC_LAT + TREE_LAT cycles (N = num_steps). Defaults: N+9.
- Arithmetic: the scheduler performs none; tree_sum is passed through at SUM_W, except when the optional feature is compiled in.
- Back-to-back jobs: minimum one IDLE cycle between done and the next accepted start.

Optional Feature:
- Macro: MAC_SCHED_RELU_EN.
- Defined: the DRAIN capture stores 0 when tree_sum is negative (MSB=1), else tree_sum unchanged.
- Undefined: the signed tree_sum is captured unchanged.
- Timing and handshakes are identical in both builds.

Test Plan:
1. Reset mid-FEED (rst=0 after 3 of 10 beats) -> all outputs 0 next edge; state IDLE; a fresh start with num_steps=2 completes normally.
2. num_steps=4, op_valid=1 continuously, every lane A=B=1.0 (0x0100), res_ready=1:
   - mac_clr pulses once; mac_en is high for exactly 4 cycles.
   - res_valid rises 13 cycles after start-accept.
   - res_data = 49*4*1.0 = 196.0, i.e. 196<<16.
3. num_steps=3 with op_valid toggling 1,0,0,1,0,1 -> exactly 3 mac_en pulses, aligned to the op_valid=1 cycles; result equal to the gap-free run.
4. res_ready held 0 for 20 cycles in OUT -> res_valid stays 1, res_data stable, tree_en=0, start ignored; done pulses in the cycle res_ready=1.
5. num_steps=0 -> CLEAR then DRAIN for 7 cycles, no mac_en; res_data=0.
6. A=-1.0 (0xFF00), B=1.0, num_steps=1 -> res_data = -49<<16 without the macro; 0 with MAC_SCHED_RELU_EN.
